// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU op sequencer: op encodings, FSM states, op-word layout.
package alu_seq_pkg;

    localparam int SEQ_DEPTH = 8;
    localparam int SEQ_AW    = 3;
    localparam int SEQ_RW    = 3;
    localparam int SEQ_LAT   = 2;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_ADD1 = 2'b01,
        OP_XOR  = 2'b10,
        OP_MUL  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_FINISH
    } state_e;

    // op word is {S[1:0], AddA[aw-1:0], AddB[aw-1:0]}
    function automatic int ofs_s(input int aw);
        return 2 * aw;
    endfunction

    function automatic int ofs_adda(input int aw);
        return aw;
    endfunction

    localparam int OFS_ADDB = 0;

endpackage

// File: rtl/alu_seq_regfile.sv
// DEPTH x RW result buffer: synchronous write, registered read (1-cycle latency, read-before-write).
// No flow control; the read port is always live.
module alu_seq_regfile #(
    parameter int DEPTH = 8,
    parameter int RW    = 3,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [RW-1:0] wdata_i,
    input  logic [IW-1:0] raddr_i,
    output logic [RW-1:0] rdata_o
);

    logic [RW-1:0] mem_q [DEPTH];
    logic [RW-1:0] rdata_q;

    // storage is deliberately not reset so partial results survive an aborted run
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Runs a stored program of ALU ops one at a time, capturing each result LAT+1 cycles after issue.
// N ops complete with done N*(LAT+1)+1 cycles after start; start/prog_we are dropped while busy.
// Optional checksum output (XOR of captured results) when ALU_SEQ_CHECKSUM_EN is defined.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = SEQ_DEPTH,
    parameter int AW    = SEQ_AW,
    parameter int RW    = SEQ_RW,
    parameter int LAT   = SEQ_LAT,
    localparam int IW   = $clog2(DEPTH),
    localparam int LW   = IW + 1,
    localparam int OPW  = 2 + 2 * AW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           prog_we,
    input  logic [IW-1:0]  prog_addr,
    input  logic [OPW-1:0] prog_data,
    input  logic [LW-1:0]  prog_len,
    input  logic           start,
    output logic [1:0]     S,
    output logic [AW-1:0]  AddA,
    output logic [AW-1:0]  AddB,
    input  logic [RW-1:0]  alu_out,
    input  logic [IW-1:0]  res_addr,
    output logic [RW-1:0]  res_data,
    output logic           busy,
    output logic           done
`ifdef ALU_SEQ_CHECKSUM_EN
    ,
    output logic [RW-1:0]  checksum
`endif
);

    localparam int CW       = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int S_LSB    = ofs_s(AW);
    localparam int ADDA_LSB = ofs_adda(AW);

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  len_sat;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [OPW-1:0] op_q, op_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           cap_we;
    logic           run_accept;
    logic           last_op;
    logic [OPW-1:0] prog_q [DEPTH];

    always_ff @(posedge clk) begin
        if (prog_we && (state_q == ST_IDLE)) begin
            prog_q[prog_addr] <= prog_data;
        end
    end

    assign len_sat    = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
    assign run_accept = (state_q == ST_IDLE) && start;
    assign last_op    = ({1'b0, idx_q} == (len_q - LW'(1)));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        cap_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d = len_sat;
                    if (len_sat == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_ISSUE;
                        op_d    = prog_q[idx_q];
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d = CW'(LAT - 1);
                if (LAT == 1) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                cap_we = 1'b1;
                idx_d  = idx_q + IW'(1);
                if (last_op) begin
                    state_d = ST_FINISH;
                end else begin
                    // next op goes out on the same edge the current result is captured
                    state_d = ST_ISSUE;
                    op_d    = prog_q[idx_q + IW'(1)];
                end
            end
            ST_FINISH: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign S    = op_q[S_LSB +: 2];
    assign AddA = op_q[ADDA_LSB +: AW];
    assign AddB = op_q[OFS_ADDB +: AW];
    assign busy = busy_q;
    assign done = done_q;

    alu_seq_regfile #(
        .DEPTH (DEPTH),
        .RW    (RW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we_i    (cap_we),
        .waddr_i (idx_q),
        .wdata_i (alu_out),
        .raddr_i (res_addr),
        .rdata_o (res_data)
    );

`ifdef ALU_SEQ_CHECKSUM_EN
    logic [RW-1:0] chk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= '0;
        end else if (run_accept) begin
            chk_q <= '0;
        end else if (cap_we) begin
            chk_q <= chk_q ^ alu_out;
        end
    end

    assign checksum = chk_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: ALU stub, run-level reference model, per-cycle compare, directed + random runs.
module tb_alu_op_sequencer;

    localparam int LAT = 2;
    localparam int P   = LAT + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       prog_we = 1'b0;
    logic [2:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic [3:0] prog_len = '0;
    logic       start = 1'b0;
    logic [1:0] S;
    logic [2:0] AddA;
    logic [2:0] AddB;
    logic [2:0] alu_out;
    logic [2:0] res_addr = '0;
    logic [2:0] res_data;
    logic       busy;
    logic       done;
`ifdef ALU_SEQ_CHECKSUM_EN
    logic [2:0] checksum;
`endif

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .start     (start),
        .S         (S),
        .AddA      (AddA),
        .AddB      (AddB),
        .alu_out   (alu_out),
        .res_addr  (res_addr),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done)
`ifdef ALU_SEQ_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    // ALU behaviour with identity ROMs (A = AddA, B = AddB), results mod 8
    function automatic logic [2:0] alu_f(input logic [7:0] w);
        logic [2:0] a;
        logic [2:0] b;
        a = w[5:3];
        b = w[2:0];
        case (w[7:6])
            2'b00:   return a + b;
            2'b01:   return a + b + 3'd1;
            2'b10:   return a ^ b;
            default: return a * b;
        endcase
    endfunction

    // stub: LAT-stage delay line from the issued op to alu_out
    logic [2:0] stage [LAT];
    always @(posedge clk) begin
        stage[0] <= alu_f({S, AddA, AddB});
        for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
    assign alu_out = stage[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: a run of N ops, each op costs P edges; op k result lands on edge (k+1)*P
    logic [7:0] m_prog [8];
    logic [2:0] m_res  [8];
    bit         m_valid[8];
    logic [7:0] m_op  = '0;
    logic [2:0] m_rd  = '0;
    logic [2:0] m_chk = '0;
    bit         m_rdv = 0;
    bit         m_active = 0;
    bit         m_fin = 0;
    bit         m_done = 0;
    int         m_rel = 0;
    int         m_n = 0;

    initial begin
        bit idle_now;
        int k;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 0; m_fin = 0; m_done = 0;
                m_op = '0; m_rd = '0; m_rdv = 1; m_chk = '0;
            end else begin
                idle_now = !m_active && !m_fin;
                m_rd  = m_res[res_addr];
                m_rdv = m_valid[res_addr];
                m_fin  = 0;
                m_done = 0;
                if (m_active) begin
                    m_rel++;
                    if (m_rel % P == 0) begin
                        k = m_rel / P - 1;
                        m_res[k]   = alu_f(m_prog[k]);
                        m_valid[k] = 1;
                        m_chk      = m_chk ^ m_res[k];
                        if (k == m_n - 1) begin
                            m_active = 0; m_done = 1; m_fin = 1;
                        end else begin
                            m_op = m_prog[k+1];
                        end
                    end
                end else if (idle_now && start) begin
                    m_n   = (prog_len > 4'd8) ? 8 : int'(prog_len);
                    m_chk = '0;
                    if (m_n == 0) begin
                        m_done = 1; m_fin = 1;
                    end else begin
                        m_active = 1; m_rel = 0; m_op = m_prog[0];
                    end
                end
                if (idle_now && prog_we) m_prog[prog_addr] = prog_data;
            end
        end
    end

    // per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("cyc_op", 32'({S, AddA, AddB}), 32'(m_op));
                chk("cyc_busy", 32'(busy), 32'(m_active));
                chk("cyc_done", 32'(done), 32'(m_done));
                if (m_rdv) chk("cyc_res", 32'(res_data), 32'(m_rd));
`ifdef ALU_SEQ_CHECKSUM_EN
                chk("cyc_checksum", 32'(checksum), 32'(m_chk));
`endif
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [2:0] v);
        res_addr = a;
        @(negedge clk);
        v = res_data;
    endtask

    // start a run; dcyc = cycles from the start cycle to the done cycle (-1 on timeout)
    task automatic run(input logic [3:0] len, input bit noisy, input int pulse_at,
                       output int dcyc, output logic [7:0] first_op);
        prog_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_op = {S, AddA, AddB};
        dcyc = -1;
        for (int i = 1; i <= 300; i++) begin
            if (done) begin
                dcyc = i;
                break;
            end
            if (i == pulse_at) begin
                start = 1'b1; prog_len = 4'd1;
                prog_we = 1'b1; prog_addr = 3'd2; prog_data = 8'hFF;
            end else if (noisy) begin
                res_addr = 3'($urandom_range(0, 7));
                start    = ($urandom_range(0, 7) == 0);
                prog_len = 4'($urandom_range(0, 12));
                prog_we  = ($urandom_range(0, 7) == 0);
                prog_addr = 3'($urandom_range(0, 7));
                prog_data = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            start = 1'b0; prog_we = 1'b0;
        end
        if (dcyc < 0) chk("run_timeout", 32'(dcyc), 32'(0));
        @(negedge clk);
        chk("done_single", 32'(done), 32'(0));
    endtask

    initial begin
        int         d;
        int         nd;
        int         rlen;
        logic [7:0] f;
        logic [2:0] v;

        #3 rst = 1'b1;
        #1 chk_on = 1;
        chk("rst_op", 32'({S, AddA, AddB}), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_res", 32'(res_data), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: single op
        wr(3'd0, {2'b00, 3'd1, 3'd2});
        run(4'd1, 0, -1, d, f);
        chk("t1_first_op", 32'(f), 32'h0A);
        chk("t1_done_cyc", 32'(d), 32'(4));
        chk("t1_busy_after", 32'(busy), 32'(0));
        rd(3'd0, v);
        chk("t1_res0", 32'(v), 32'(3));

        // 2: eight XOR ops, each i ^ (7-i) = 7
        for (int i = 0; i < 8; i++) wr(3'(i), {2'b10, 3'(i), 3'(7 - i)});
        run(4'd8, 0, -1, d, f);
        chk("t2_first_op", 32'(f), 32'h87);
        chk("t2_done_cyc", 32'(d), 32'(25));
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            chk("t2_res", 32'(v), 32'(7));
        end

        // 3: zero length, then oversize length saturating to 8
        run(4'd0, 0, -1, d, f);
        chk("t3_len0_done", 32'(d), 32'(1));
        chk("t3_len0_op_held", 32'(f), 32'hB8);
        rd(3'd0, v);
        chk("t3_len0_res", 32'(v), 32'(7));
        run(4'd12, 0, -1, d, f);
        chk("t3_len12_done", 32'(d), 32'(25));

        // 4: start/prog_we pulsed mid-run are dropped
        for (int i = 0; i < 8; i++) wr(3'(i), {2'b01, 3'(i), 3'd0});
        run(4'd8, 0, 5, d, f);
        chk("t4_done_cyc", 32'(d), 32'(25));
        repeat (3) @(negedge clk);
        chk("t4_no_second_run", 32'(busy), 32'(0));
        rd(3'd2, v);
        chk("t4_res2", 32'(v), 32'(3));
        run(4'd3, 0, -1, d, f);
        rd(3'd2, v);
        chk("t4_prog_unchanged", 32'(v), 32'(3));

        // 5: reset in WAIT of op 3
        for (int i = 0; i < 8; i++) wr(3'(i), {2'b11, 3'(i), 3'd3});
        rd(3'd3, v);
        chk("t5_res3_before", 32'(v), 32'(4));
        prog_len = 4'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_busy_pre", 32'(busy), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_op", 32'({S, AddA, AddB}), 32'(0));
        chk("t5_rst_busy", 32'(busy), 32'(0));
        chk("t5_rst_done", 32'(done), 32'(0));
        chk("t5_rst_res", 32'(res_data), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("t5_no_done", 32'(nd), 32'(0));
        rd(3'd0, v); chk("t5_res0", 32'(v), 32'(0));
        rd(3'd1, v); chk("t5_res1", 32'(v), 32'(3));
        rd(3'd2, v); chk("t5_res2", 32'(v), 32'(6));
        rd(3'd3, v); chk("t5_res3_kept", 32'(v), 32'(4));
        run(4'd1, 0, -1, d, f);
        chk("t5_fresh_first_op", 32'(f), 32'hC3);
        chk("t5_fresh_done", 32'(d), 32'(4));

`ifdef ALU_SEQ_CHECKSUM_EN
        // 6: checksum across a run, cleared by the next run
        wr(3'd0, {2'b00, 3'd1, 3'd1});
        wr(3'd1, {2'b11, 3'd3, 3'd2});
        wr(3'd2, {2'b10, 3'd5, 3'd1});
        run(4'd3, 0, -1, d, f);
        chk("t6_checksum_a", 32'(checksum), 32'(0));
        wr(3'd0, {2'b00, 3'd1, 3'd2});
        run(4'd1, 0, -1, d, f);
        chk("t6_checksum_b", 32'(checksum), 32'(3));
`endif

        // random programs and runs with noise on the inputs during runs
        for (int r = 0; r < 25; r++) begin
            nd = $urandom_range(0, 4);
            for (int w = 0; w < nd; w++) wr(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            res_addr = 3'($urandom_range(0, 7));
            rlen = $urandom_range(0, 12);
            run(4'(rlen), 1, -1, d, f);
            chk("rand_done_cyc", 32'(d), 32'(((rlen > 8) ? 8 : rlen) * P + 1));
        end
        for (int i = 0; i < 8; i++) rd(3'(i), v);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
